// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, FSM states
// and the alignment predicate used by both the LSU and the retire checker.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  // Size 2'b11 is illegal and reported through the same trap as misalignment.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = addr_lo[0];
      SZ_W:    misaligned = (addr_lo != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store mask and data shift, load shift and sign/zero
// extension. Purely combinational so the retire checker can reuse it.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  mask,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext
);

  logic [4:0]  shamt_s;
  logic [31:0] rdata_sh_s;

  assign shamt_s    = {addr_lo, 3'b000};
  assign wdata_sh   = wdata << shamt_s;
  assign rdata_sh_s = rdata >> shamt_s;

  // Lane mask and load extension selected by access size.
  always_comb begin
    mask      = 4'b0000;
    rdata_ext = 32'h0000_0000;
    case (size)
      SZ_B: begin
        mask      = 4'b0001 << addr_lo;
        rdata_ext = is_unsigned ? {24'h00_0000, rdata_sh_s[7:0]}
                                : {{24{rdata_sh_s[7]}}, rdata_sh_s[7:0]};
      end
      SZ_H: begin
        mask      = 4'b0011 << addr_lo;
        rdata_ext = is_unsigned ? {16'h0000, rdata_sh_s[15:0]}
                                : {{16{rdata_sh_s[15]}}, rdata_sh_s[15:0]};
      end
      SZ_W: begin
        mask      = 4'b1111;
        rdata_ext = rdata_sh_s;
      end
      default: begin
        mask      = 4'b0000;
        rdata_ext = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Multi-cycle load/store unit: handshaked data-memory port with alignment
// checking, lane steering, load extension and an optional timeout watchdog.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wen,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_resp_valid,
  output logic [31:0]       o_resp_rdata,
  output logic              o_resp_trap,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_ren,
  output logic              o_mem_wen,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_mask,
  input  logic              i_mem_ready,
  input  logic              i_mem_valid,
  input  logic [31:0]       i_mem_rdata
);

  localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

  state_e      state_r;
  logic        req_wen_r;
  logic        req_uns_r;
  logic [1:0]  req_size_r;
  logic [1:0]  addr_lo_r;
  logic [31:0] wd_cnt_r;

  logic [1:0]  al_size_s;
  logic        al_uns_s;
  logic [1:0]  al_addr_s;
  logic [3:0]  al_mask_s;
  logic [31:0] al_wdata_s;
  logic [31:0] al_rdata_s;
  logic        accept_s;
  logic        in_mem_s;
  logic        timeout_s;

  // Aligner sees the incoming request in IDLE and the captured one afterwards.
  always_comb begin
    if (state_r == ST_IDLE) begin
      al_size_s = i_req_size;
      al_uns_s  = i_req_unsigned;
      al_addr_s = i_req_addr[1:0];
    end else begin
      al_size_s = req_size_r;
      al_uns_s  = req_uns_r;
      al_addr_s = addr_lo_r;
    end
  end

  lsu_align u_align (
    .size        (al_size_s),
    .is_unsigned (al_uns_s),
    .addr_lo     (al_addr_s),
    .wdata       (i_req_wdata),
    .rdata       (i_mem_rdata),
    .mask        (al_mask_s),
    .wdata_sh    (al_wdata_s),
    .rdata_ext   (al_rdata_s)
  );

  assign accept_s  = o_req_ready & i_req_valid;
  assign in_mem_s  = (state_r == ST_ISSUE) | (state_r == ST_WAIT);
  assign timeout_s = (TIMEOUT > 0) && in_mem_s && (wd_cnt_r == TIMEOUT_W);

  // Transaction FSM; every output is registered and follows the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r      <= ST_IDLE;
      req_wen_r    <= 1'b0;
      req_uns_r    <= 1'b0;
      req_size_r   <= 2'b00;
      addr_lo_r    <= 2'b00;
      wd_cnt_r     <= 32'h0;
      o_req_ready  <= 1'b0;
      o_resp_valid <= 1'b0;
      o_resp_rdata <= 32'h0;
      o_resp_trap  <= 1'b0;
      o_busy       <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_ren    <= 1'b0;
      o_mem_wen    <= 1'b0;
      o_mem_wdata  <= 32'h0;
      o_mem_mask   <= 4'b0000;
    end else begin
      o_resp_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            req_wen_r   <= i_req_wen;
            req_uns_r   <= i_req_unsigned;
            req_size_r  <= i_req_size;
            addr_lo_r   <= i_req_addr[1:0];
            o_req_ready <= 1'b0;
            o_busy      <= 1'b1;
            if (misaligned(i_req_size, i_req_addr[1:0])) begin
              state_r      <= ST_RESP;
              o_resp_valid <= 1'b1;
              o_resp_trap  <= 1'b1;
              o_resp_rdata <= 32'h0;
            end else begin
              state_r     <= ST_ISSUE;
              wd_cnt_r    <= 32'h0;
              o_mem_ren   <= ~i_req_wen;
              o_mem_wen   <= i_req_wen;
              o_mem_addr  <= {i_req_addr[ADDR_W-1:2], 2'b00};
              o_mem_mask  <= al_mask_s;
              o_mem_wdata <= al_wdata_s;
            end
          end else begin
            o_req_ready <= 1'b1;
            o_busy      <= 1'b0;
          end
        end
        ST_ISSUE, ST_WAIT: begin
          wd_cnt_r <= wd_cnt_r + 32'd1;
          // The watchdog wins: a late memory response is not accepted.
          if (timeout_s) begin
            state_r      <= ST_RESP;
            o_mem_ren    <= 1'b0;
            o_mem_wen    <= 1'b0;
            o_resp_valid <= 1'b1;
            o_resp_trap  <= 1'b1;
            o_resp_rdata <= 32'h0;
          end else if ((state_r == ST_WAIT) || i_mem_ready) begin
            o_mem_ren <= 1'b0;
            o_mem_wen <= 1'b0;
            if (i_mem_valid) begin
              state_r      <= ST_RESP;
              o_resp_valid <= 1'b1;
              o_resp_trap  <= 1'b0;
              o_resp_rdata <= req_wen_r ? 32'h0 : al_rdata_s;
            end else begin
              state_r <= ST_WAIT;
            end
          end else begin
            state_r <= ST_ISSUE;
          end
        end
        ST_RESP: begin
          state_r     <= ST_IDLE;
          o_req_ready <= 1'b1;
          o_busy      <= 1'b0;
        end
        default: begin
          state_r     <= ST_IDLE;
          o_req_ready <= 1'b1;
          o_busy      <= 1'b0;
          o_mem_ren   <= 1'b0;
          o_mem_wen   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table, randomized traffic
// against a byte-lane memory model, and reset-abort sequences.
module tb_lsu;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid, i_req_wen, i_req_unsigned;
  logic [1:0]  i_req_size;
  logic [31:0] i_req_addr, i_req_wdata;
  logic        o_req_ready, o_resp_valid, o_resp_trap, o_busy;
  logic [31:0] o_resp_rdata, o_mem_addr, o_mem_wdata;
  logic        o_mem_ren, o_mem_wen;
  logic [3:0]  o_mem_mask;
  logic        i_mem_ready, i_mem_valid;
  logic [31:0] i_mem_rdata;

  lsu #(.ADDR_W(32), .TIMEOUT(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_wen(i_req_wen), .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata), .o_resp_trap(o_resp_trap),
    .o_busy(o_busy), .o_mem_addr(o_mem_addr), .o_mem_ren(o_mem_ren), .o_mem_wen(o_mem_wen),
    .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
    .i_mem_ready(i_mem_ready), .i_mem_valid(i_mem_valid), .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        wen;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stall;
    int          lat;
    logic [31:0] exp_rdata;
    logic        exp_trap;
    int          exp_cyc;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] mem [int unsigned];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] addr);
    return mem.exists(addr >> 2) ? mem[addr >> 2] : 32'h0;
  endfunction

  function automatic logic is_mis(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || ((addr % (32'd1 << size)) != 32'd0);
  endfunction

  // Load value from the memory word by byte arithmetic.
  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] size,
                                             input logic uns, input logic [31:0] addr);
    longint unsigned full, v;
    full = 64'd1 << (8 * (1 << size));
    v = (64'(word) >> (8 * (addr % 4))) % full;
    if (!uns && size != 2'd2 && v >= full / 2) v = v + (64'h1_0000_0000 - full);
    return 32'(v);
  endfunction

  // Present one request, play the memory side, and check the response.
  task automatic run(input vec_t v, input string tag);
    int cyc, issued, waited, idx, nb;
    bit handed, done;
    logic [3:0] emask;
    logic [31:0] w;
    idx = int'(v.addr[1:0]);
    nb = 1 << v.size;
    emask = 4'(((1 << nb) - 1) << idx);
    cyc = 0; issued = 0; waited = 0; handed = 0; done = 0;
    @(negedge i_clk);
    chk({tag, ".req_ready"}, 32'(o_req_ready), 32'd1);
    i_req_valid = 1'b1; i_req_wen = v.wen; i_req_size = v.size;
    i_req_unsigned = v.uns; i_req_addr = v.addr; i_req_wdata = v.wdata;
    while (!done && cyc < 40) begin
      @(negedge i_clk);
      cyc++;
      i_req_valid = 1'b0; i_mem_ready = 1'b0; i_mem_valid = 1'b0;
      if (o_resp_valid) begin
        done = 1;
        chk({tag, ".rdata"}, o_resp_rdata, v.exp_rdata);
        chk({tag, ".trap"}, 32'(o_resp_trap), 32'(v.exp_trap));
        chk({tag, ".latency"}, 32'(cyc), 32'(v.exp_cyc));
        chk({tag, ".memreq_at_resp"}, {30'd0, o_mem_ren, o_mem_wen}, 32'd0);
      end else if (!handed) begin
        if (o_mem_ren || o_mem_wen) begin
          chk({tag, ".ren_wen"}, {30'd0, o_mem_ren, o_mem_wen}, {30'd0, ~v.wen, v.wen});
          chk({tag, ".addr"}, o_mem_addr, v.addr & ~32'd3);
          chk({tag, ".mask"}, 32'(o_mem_mask), 32'(emask));
          if (v.wen)
            for (int j = 0; j < nb && idx + j < 4; j++)
              chk({tag, ".wdata_lane"}, 32'(o_mem_wdata[8*(idx+j) +: 8]), 32'(v.wdata[8*j +: 8]));
          issued++;
          if (issued > v.stall) begin
            i_mem_ready = 1'b1;
            handed = 1;
            if (v.wen) begin
              w = rd(v.addr);
              for (int j = 0; j < nb && idx + j < 4; j++) w[8*(idx+j) +: 8] = v.wdata[8*j +: 8];
              mem[v.addr >> 2] = w;
            end
            if (v.lat == 0) begin i_mem_valid = 1'b1; i_mem_rdata = rd(v.addr); end
          end
        end
      end else begin
        chk({tag, ".wait_idle_bus"}, {30'd0, o_mem_ren, o_mem_wen}, 32'd0);
        waited++;
        if (waited >= v.lat) begin i_mem_valid = 1'b1; i_mem_rdata = rd(v.addr); end
      end
    end
    if (!done) chk({tag, ".response_seen"}, 32'd0, 32'd1);
    i_mem_ready = 1'b0; i_mem_valid = 1'b0;
  endtask

  vec_t vecs[14];
  vec_t rv;

  initial begin
    i_rst = 1'b1; i_req_valid = 1'b0; i_req_wen = 1'b0; i_req_size = 2'b00;
    i_req_unsigned = 1'b0; i_req_addr = 32'h0; i_req_wdata = 32'h0;
    i_mem_ready = 1'b0; i_mem_valid = 1'b0; i_mem_rdata = 32'h0;
    mem[32'h1000 >> 2] = 32'h80FF_FF00;
    mem[32'h4000 >> 2] = 32'h8001_0000;

    //          wen   size   uns   addr        wdata         st  lat  exp_rdata     trap  cyc
    vecs[0]  = '{1'b0, 2'd0, 1'b0, 32'h1003, 32'h0,        0,   0, 32'hFFFF_FF80, 1'b0, 2};
    vecs[1]  = '{1'b1, 2'd1, 1'b0, 32'h2002, 32'h1234_ABCD, 3,  0, 32'h0,         1'b0, 5};
    vecs[2]  = '{1'b0, 2'd2, 1'b0, 32'h3001, 32'h0,        0,   0, 32'h0,         1'b1, 1};
    vecs[3]  = '{1'b0, 2'd2, 1'b0, 32'h5000, 32'h0,        100, 0, 32'h0,         1'b1, 10};
    vecs[4]  = '{1'b0, 2'd1, 1'b1, 32'h4002, 32'h0,        0,   0, 32'h0000_8001, 1'b0, 2};
    vecs[5]  = '{1'b1, 2'd2, 1'b0, 32'h4004, 32'hDEAD_BEEF, 0,  0, 32'h0,         1'b0, 2};
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h1002, 32'h0,        0,   0, 32'hFFFF_80FF, 1'b0, 2};
    vecs[7]  = '{1'b0, 2'd0, 1'b1, 32'h1001, 32'h0,        1,   1, 32'h0000_00FF, 1'b0, 4};
    vecs[8]  = '{1'b0, 2'd3, 1'b0, 32'h1000, 32'h0,        0,   0, 32'h0,         1'b1, 1};
    vecs[9]  = '{1'b1, 2'd1, 1'b0, 32'h2001, 32'h5555_5555, 0,  0, 32'h0,         1'b1, 1};
    vecs[10] = '{1'b0, 2'd2, 1'b0, 32'h4004, 32'h0,        0,  20, 32'h0,         1'b1, 10};
    vecs[11] = '{1'b0, 2'd2, 1'b0, 32'h4004, 32'h0,        0,   0, 32'hDEAD_BEEF, 1'b0, 2};
    vecs[12] = '{1'b0, 2'd2, 1'b0, 32'h2000, 32'h0,        2,   1, 32'hABCD_0000, 1'b0, 5};
    vecs[13] = '{1'b0, 2'd0, 1'b0, 32'h4007, 32'h0,        0,   0, 32'hFFFF_FFDE, 1'b0, 2};

    repeat (3) @(negedge i_clk);
    chk("reset.req_ready", 32'(o_req_ready), 32'd0);
    chk("reset.flags", {26'd0, o_resp_valid, o_resp_trap, o_busy, o_mem_ren, o_mem_wen, 1'b0}, 32'd0);
    chk("reset.rdata", o_resp_rdata, 32'd0);
    chk("reset.mask", 32'(o_mem_mask), 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("post_reset.req_ready", 32'(o_req_ready), 32'd1);
    chk("post_reset.busy", 32'(o_busy), 32'd0);

    for (int i = 0; i < 14; i++) run(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 60; i++) begin
      rv.wen = 1'($urandom_range(0, 1));
      rv.size = 2'($urandom_range(0, 3));
      rv.uns = 1'($urandom_range(0, 1));
      rv.addr = 32'h6000 + 32'($urandom_range(0, 63));
      rv.wdata = $urandom;
      rv.stall = $urandom_range(0, 3);
      rv.lat = $urandom_range(0, 3);
      rv.exp_trap = is_mis(rv.size, rv.addr);
      rv.exp_rdata = (rv.exp_trap || rv.wen) ? 32'h0 : model_load(rd(rv.addr), rv.size, rv.uns, rv.addr);
      rv.exp_cyc = rv.exp_trap ? 1 : rv.stall + rv.lat + 2;
      run(rv, $sformatf("rand%0d", i));
    end

    // Reset while WAITing: abandoned, no response.
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_wen = 1'b0; i_req_size = 2'd2; i_req_addr = 32'h6000;
    @(negedge i_clk);
    i_req_valid = 1'b0; i_mem_ready = 1'b1;
    @(negedge i_clk);
    i_mem_ready = 1'b0;
    chk("rst_wait.busy_before", 32'(o_busy), 32'd1);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("rst_wait.busy", 32'(o_busy), 32'd0);
    chk("rst_wait.resp_valid", 32'(o_resp_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      chk("rst_wait.no_resp", 32'(o_resp_valid), 32'd0);
    end
    chk("rst_wait.req_ready", 32'(o_req_ready), 32'd1);

    // Reset while ISSUEing: memory request drops the next cycle.
    i_req_valid = 1'b1; i_req_wen = 1'b1; i_req_size = 2'd0; i_req_addr = 32'h6001;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    chk("rst_issue.wen_before", 32'(o_mem_wen), 32'd1);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("rst_issue.memreq", {30'd0, o_mem_ren, o_mem_wen}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      chk("rst_issue.no_resp", 32'(o_resp_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Multi-cycle load/store unit for the WISC-25 hart, replacing the combinational single-cycle dmem path with a handshaked memory interface that tolerates variable latency. It accepts one load or store per transaction from the execute stage. It performs alignment checking, byte-lane masking and shifting, and load sign/zero extension, and flags traps for misalignment and memory timeout. It sits between the hart datapath and the data memory; the hart stalls on `o_busy`.

## Interface
- `ADDR_W`, 32, address width on both request and memory sides.
- `TIMEOUT`, 0, max cycles spent in ISSUE+WAIT before a timeout trap; 0 disables the watchdog.

- `i_clk` in 1 — clock.
- `i_rst` in 1 — reset, synchronous, active-high.
- `i_req_valid` in 1 — core presents an operation.
- `o_req_ready` out 1 — LSU in IDLE and able to accept.
- `i_req_wen` in 1 — 1 = store, 0 = load.
- `i_req_size` in 2 — 00 byte, 01 half, 10 word, 11 illegal.
- `i_req_unsigned` in 1 — zero-extend the load (lbu/lhu).
- `i_req_addr` in ADDR_W — byte address.
- `i_req_wdata` in 32 — store data, right-justified (r[rs2]).
- `o_resp_valid` out 1 — one-cycle completion pulse.
- `o_resp_rdata` out 32 — extended load result; 0 for stores and traps.
- `o_resp_trap` out 1 — misaligned, illegal size, or timeout; qualified by `o_resp_valid`.
- `o_busy` out 1 — state != IDLE.
- `o_mem_addr` out ADDR_W — word-aligned address, `{addr[ADDR_W-1:2],2'b00}`.
- `o_mem_ren` / `o_mem_wen` out 1 — read or write request; never both asserted.
- `o_mem_wdata` out 32 — lane-shifted store data.
- `o_mem_mask` out 4 — byte-lane enables.
- `i_mem_ready` in 1 — memory accepts the request this cycle.
- `i_mem_valid` in 1 — read data valid, or write acknowledged.
- `i_mem_rdata` in 32 — read word.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - `o_req_ready`=1.
  - On `i_req_valid`, capture all request fields.
  - If misaligned (half with addr[0]=1; word with addr[1:0]!=0; size 11), go to RESP with trap set; no memory access is made.
  - Otherwise go to ISSUE.
- ISSUE: drive `ren`/`wen`, addr, mask and wdata, held stable until `i_mem_ready`.
  - `ready` & `valid` in the same cycle -> RESP.
  - `ready` only -> WAIT.
- WAIT: all memory requests deasserted. On `i_mem_valid`, latch the result -> RESP.
- RESP: `o_resp_valid`=1 for exactly one cycle -> IDLE.
- `i_mem_valid` is sampled only in WAIT, or in ISSUE together with `i_mem_ready`; otherwise it is ignored.
- Mask generation:
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << addr[1:0]`
  - word: `4'b1111`
- Store data: `wdata << (8*addr[1:0])`.
- Load data: `rdata >> (8*addr[1:0])`, then bits [7:0] or [15:0] are sign- or zero-extended per `i_req_unsigned`; a word load passes through unchanged.
- Watchdog (TIMEOUT>0):
  - Counter clears on entry to ISSUE and increments each cycle in ISSUE or WAIT.
  - When the count reaches TIMEOUT: go to RESP with trap set, rdata=0, memory requests dropped.
  - Memory must not respond after a timeout.

## Timing
- While `i_rst` is high and on the cycle after it: state IDLE, every output 0 except `o_req_ready`, which is 1 from the first cycle after reset is deasserted.
- Request accepted at cycle N:
  - ISSUE at N+1.
  - Zero-wait memory gives `o_resp_valid` at N+2.
  - Each memory stall cycle adds one.
- Misaligned request accepted at N: trap response at N+1.
- `o_resp_rdata`/`o_resp_trap` are registered and hold until the next response.
- Back-to-back operation: a new request can be accepted the cycle after RESP, giving at best one operation every 3 cycles.
- Reset mid-operation:
  - Transaction abandoned.
  - Memory request drops on the cycle after the reset edge.
  - No response is produced.

## Structure
- Shared package `lsu_pkg`: size encodings (`SZ_B`, `SZ_H`, `SZ_W`), state enum, and the misalign predicate as a function.
- Sub-module `lsu_align`: combinational mask, store shift, load shift and extend; reused by the hart's retire checker.

## Test plan
- `lb` at 0x1003, zero-wait memory returning rdata 0x80FF_FF00: mask 1000, `o_resp_rdata` 0xFFFF_FF80, resp at N+2.
- `sh` of 0x1234ABCD at 0x2002, memory ready after 3 stall cycles: mask 1100, wdata 0xABCD_xxxx held stable for all 4 ISSUE cycles, resp at N+5, no trap.
- `lw` at 0x3001: trap at N+1, no `ren` ever asserted, rdata 0.
- TIMEOUT=8, `i_mem_ready` held low: trap at N+1+8+1; `ren` falls with the transition to RESP.
- `lhu` at 0x4002, rdata 0x8001_0000, then immediate `sw` to 0x4004: first result 0x0000_8001; second request accepted the cycle after RESP.
- `i_rst` asserted during WAIT: next cycle IDLE, `o_busy`=0, no `o_resp_valid` pulse.
